// File: rtl/mem_access_ctrl.sv
// Memory-access sequencer between the microcoded control unit and a synchronous
// single-port memory. One access in flight at a time; results go to the MBR/MBRU path.
module mem_access_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        mem_ctrl,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic [ADDR_W-1:0] ar_addr,
  input  logic [DATA_W-1:0] dr_wdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mbr_data,
  output logic [5:0]        mbru,
  output logic              mbr_valid,
  output logic              done,
  output logic              busy,
  output logic              err,
  output logic [1:0]        dbg_state
);

  // Handshake: a one-hot mem_ctrl is a request, taken at any edge where the
  // sequencer is in IDLE or DONE; done (and mbr_valid for reads) pulses one
  // cycle to mark completion. Requests seen while busy are dropped and flag err.

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam logic [2:0] K_FETCH = 3'b100;
  localparam logic [2:0] K_READ  = 3'b010;
  localparam logic [2:0] K_WRITE = 3'b001;

  state_t              r_state;
  logic [2:0]          r_kind;
  logic [3:0]          r_cnt;
  logic                r_mem_en;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_mbr_data;
  logic [5:0]          r_mbru;
  logic                r_mbr_valid;
  logic                r_done;
  logic                r_busy;
  logic                r_err;

  logic                w_onehot;
  logic                w_any;
  logic [ADDR_W-1:0]   w_sel_addr;

  assign w_onehot   = (mem_ctrl == K_FETCH) || (mem_ctrl == K_READ) || (mem_ctrl == K_WRITE);
  assign w_any      = (mem_ctrl != 3'b000);
  assign w_sel_addr = (mem_ctrl == K_FETCH) ? pc_addr : ar_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_kind      <= 3'b000;
      r_cnt       <= 4'd0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mbr_data  <= '0;
      r_mbru      <= 6'd0;
      r_mbr_valid <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mbr_valid <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          if (w_onehot) begin
            r_kind     <= mem_ctrl;
            r_mem_en   <= 1'b1;
            r_mem_addr <= w_sel_addr;
            if (mem_ctrl == K_WRITE) begin
              r_mem_we    <= 1'b1;
              r_mem_wdata <= dr_wdata;
            end
            r_busy  <= 1'b1;
            r_state <= S_REQ;
          end else if (w_any) begin
            r_err <= 1'b1;
          end
        end
        S_REQ: begin
          if (w_any) r_err <= 1'b1;
          if (r_kind == K_WRITE) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_cnt   <= 4'(MEM_LATENCY);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_any) r_err <= 1'b1;
          r_cnt <= r_cnt - 4'd1;
          // Counter reaching zero on this edge means mem_rdata is valid now.
          if (r_cnt == 4'd1) begin
            r_mbr_data <= mem_rdata;
            if (r_kind == K_FETCH) r_mbru <= mem_rdata[DATA_W-1 -: 6];
            r_mbr_valid <= 1'b1;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mbr_data  = r_mbr_data;
  assign mbru      = r_mbru;
  assign mbr_valid = r_mbr_valid;
  assign done      = r_done;
  assign busy      = r_busy;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-access sequencer directly downstream of the microcoded control unit.
- Consumes the 3-bit memory-control field of the control word (bits [8:6]: 100 = instruction fetch, 010 = data read, 001 = data write).
- Drives a synchronous single-port memory that holds both program and image data, with configurable read latency.
- Returns read data to the MBR path, and returns the fetched opcode field (MBRU) to the control unit for FETCH2 dispatch.

Parameters:
- ADDR_W, 16, width of PC/AR and memory address.
- DATA_W, 16, memory word width; must be ≥ 6.
- MEM_LATENCY, 1, memory read latency in clock edges after the enable edge; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- mem_ctrl  in  3  control-word bits [8:6].
- pc_addr  in  ADDR_W  program counter; address for instruction fetch.
- ar_addr  in  ADDR_W  address register; address for data read/write.
- dr_wdata  in  DATA_W  data register; write data.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- mbr_data  out  DATA_W  last captured read word (instruction or data).
- mbru  out  6  mbr_data[DATA_W-1:DATA_W-6] of last instruction fetch only.
- mbr_valid  out  1  one-cycle pulse when mbr_data is updated.
- done  out  1  one-cycle pulse when any access completes.
- busy  out  1  access in progress.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, counter=0. All outputs 0 (mem_en, mem_we, mem_addr, mem_wdata, mbr_data, mbru, mbr_valid, done, busy, err). Reset applies mid-access too: the access is abandoned and no capture or done pulse is produced.
- Accepting states: IDLE and DONE.
  - mem_ctrl=000: no action.
  - mem_ctrl one-hot: latch kind; latch address (pc_addr for 100, else ar_addr); latch dr_wdata for 001; go to REQ.
  - Multi-hot code: set err, no access.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: busy=0.
  - REQ (exactly 1 cycle): mem_en=1, mem_addr=latched address. For a write, also mem_we=1 and mem_wdata=latched data. Write: next state DONE. Read: load counter with MEM_LATENCY, next state WAIT.
  - WAIT: mem_en=0. Decrement counter each edge. At the edge where the counter reaches 0:
    - capture mem_rdata into mbr_data;
    - if kind is fetch, also load mbru from mem_rdata[DATA_W-1:DATA_W-6];
    - go to DONE.
  - DONE (1 cycle): done=1; mbr_valid=1 for reads only; busy=0. A command present this cycle is accepted (back-to-back). Otherwise go to IDLE.
- busy=1 in REQ and WAIT.
- Any non-000 mem_ctrl sampled while busy=1 sets err and is otherwise ignored; the access in flight continues unaffected.
- err is cleared only by rst.
- mem_addr and mem_wdata hold their last values outside REQ. mem_we is never 1 outside REQ.
- Latency from the command cycle (edge E0 accepts):
  - Write: mem_we high in cycle after E0; done in the following cycle.
  - Read: done/mbr_valid high in the cycle after edge E0+1+MEM_LATENCY.
- mbr_data and mbru persist until the next capture. A data read never alters mbru.
- Address and data are latched at acceptance; input changes afterwards have no effect.

Test Plan:
- Fetch, MEM_LATENCY=1: mem word at 0x0000 = 0x2C05, pc_addr=0x0000, mem_ctrl=100 for 1 cycle -> mem_en pulse with mem_addr=0x0000; 3 edges after acceptance mbr_data=0x2C05, mbru=6'd11, mbr_valid=done=1 for 1 cycle; busy high for 2 cycles.
- Write then read, MEM_LATENCY=3: ar_addr=0x0100, dr_wdata=0x00A7, mem_ctrl=001 -> mem_we=1 for exactly 1 cycle, done next cycle. Then mem_ctrl=010 in the DONE cycle (back-to-back) -> mbr_data=0x00A7 five edges after acceptance; mbru unchanged.
- Overrun: issue 010; 1 cycle later drive 100 while busy -> err=1 and stays 1; the first read completes normally; no second access (mem_en pulses once).
- Illegal code 110 in IDLE -> err=1, mem_en stays 0, busy stays 0.
- Reset mid-WAIT (MEM_LATENCY=4, rst at 2nd WAIT cycle) -> next cycle all outputs 0, no done/mbr_valid pulse; a fresh fetch afterwards completes normally.
- Address latching: change ar_addr from 0x0010 to 0x0020 in the REQ cycle of a read accepted with 0x0010 -> mem_addr=0x0010 and the returned word comes from 0x0010.
